// File: rtl/pin_entry_ctrl_pkg.sv
// Shared definitions for the ATM PIN entry front end: FSM states, keypad codes and PIN arithmetic.
package pin_entry_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_WAIT    = 3'd2,
      S_GRANTED = 3'd3,
      S_LOCKED  = 3'd4
   } state_e;

   localparam logic [3:0] KEY_CLEAR  = 4'hA;
   localparam logic [3:0] KEY_ENTER  = 4'hB;
   localparam logic [3:0] KEY_CANCEL = 4'hC;

   localparam int unsigned PIN_DIGITS = 4;

   // pin*10 + d as shift-and-add; never overflows 16 bits for at most four digits
   function automatic logic [15:0] pin_shift_in(input logic [15:0] pin_val,
                                                input logic [3:0]  digit);
      return (pin_val << 3) + (pin_val << 1) + {12'd0, digit};
   endfunction

endpackage

// File: rtl/pin_entry_ctrl_inactivity_timer.sv
// Keypad inactivity timer: counts while run is high, expire flags the last cycle of the window.
module inactivity_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned TMR_W          = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expire
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] count_q, count_d;

   assign expire = run && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run && !expire) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pin_entry_ctrl.sv
// ATM PIN entry controller: card capture, decimal PIN accumulation, authenticator handshake,
// failed-attempt counting with card retention.
module pin_entry_ctrl
   import pin_entry_ctrl_pkg::*;
#(
   parameter int unsigned MAX_ATTEMPTS   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned TMR_W          = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_in,
   input  logic [3:0]  card_acc_num,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        auth_done,
   input  logic        auth_ok,
   input  logic        session_end,
   input  logic        admin_unlock,
   output logic        auth_req,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic [2:0]  digit_cnt,
   output logic [1:0]  fail_cnt,
   output logic        session_ok,
   output logic        locked,
   output logic        card_eject
);

   state_e      state_q, state_d;
   logic [3:0]  acc_q, acc_d;
   logic [15:0] pin_q, pin_d;
   logic [2:0]  dcnt_q, dcnt_d;
   logic [1:0]  fail_q, fail_d;
   logic        auth_req_q, auth_req_d;
   logic        session_ok_q, session_ok_d;
   logic        locked_q, locked_d;
   logic        eject_q, eject_d;

   logic in_entry;
   logic tmr_clear;
   logic tmr_expire;

   // Held at zero outside ENTRY, so every arrival in ENTRY starts a fresh window.
   assign in_entry  = (state_q == S_ENTRY);
   assign tmr_clear = !in_entry || key_valid;

   inactivity_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TMR_W         (TMR_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (in_entry),
      .clear (tmr_clear),
      .expire(tmr_expire)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      pin_d   = pin_q;
      dcnt_d  = dcnt_q;
      fail_d  = fail_q;
      eject_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (card_in) begin
               acc_d   = card_acc_num;
               pin_d   = '0;
               dcnt_d  = '0;
               fail_d  = '0;
               state_d = S_ENTRY;
            end
         end

         S_ENTRY: begin
            // A key arriving in the expiry cycle takes priority over the timeout.
            if (key_valid) begin
               if (key_code <= 4'd9) begin
                  if (dcnt_q < 3'(PIN_DIGITS)) begin
                     pin_d  = pin_shift_in(pin_q, key_code);
                     dcnt_d = dcnt_q + 3'd1;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  pin_d  = '0;
                  dcnt_d = '0;
               end else if (key_code == KEY_ENTER) begin
                  if (dcnt_q == 3'(PIN_DIGITS)) begin
                     state_d = S_WAIT;
                  end
               end else if (key_code == KEY_CANCEL) begin
                  eject_d = 1'b1;
                  pin_d   = '0;
                  dcnt_d  = '0;
                  state_d = S_IDLE;
               end
            end else if (tmr_expire) begin
               eject_d = 1'b1;
               pin_d   = '0;
               dcnt_d  = '0;
               state_d = S_IDLE;
            end
         end

         S_WAIT: begin
            if (auth_done) begin
               if (auth_ok) begin
                  state_d = S_GRANTED;
               end else if ({1'b0, fail_q} + 3'd1 == 3'(MAX_ATTEMPTS)) begin
                  fail_d  = fail_q + 2'd1;
                  state_d = S_LOCKED;
               end else begin
                  fail_d  = fail_q + 2'd1;
                  pin_d   = '0;
                  dcnt_d  = '0;
                  state_d = S_ENTRY;
               end
            end
         end

         S_GRANTED: begin
            if (session_end) begin
               eject_d = 1'b1;
               pin_d   = '0;
               dcnt_d  = '0;
               state_d = S_IDLE;
            end
         end

         S_LOCKED: begin
            if (admin_unlock) begin
               fail_d  = '0;
               pin_d   = '0;
               dcnt_d  = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      auth_req_d   = (state_d == S_WAIT);
      session_ok_d = (state_d == S_GRANTED);
      locked_d     = (state_d == S_LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         pin_q        <= '0;
         dcnt_q       <= '0;
         fail_q       <= '0;
         auth_req_q   <= 1'b0;
         session_ok_q <= 1'b0;
         locked_q     <= 1'b0;
         eject_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         pin_q        <= pin_d;
         dcnt_q       <= dcnt_d;
         fail_q       <= fail_d;
         auth_req_q   <= auth_req_d;
         session_ok_q <= session_ok_d;
         locked_q     <= locked_d;
         eject_q      <= eject_d;
      end
   end

   assign auth_req   = auth_req_q;
   assign acc_num    = acc_q;
   assign pin        = pin_q;
   assign digit_cnt  = dcnt_q;
   assign fail_cnt   = fail_q;
   assign session_ok = session_ok_q;
   assign locked     = locked_q;
   assign card_eject = eject_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Self-checking bench for pin_entry_ctrl: directed scenarios then random traffic against a
// digit-list reference model.
module tb_pin_entry_ctrl;

   localparam int unsigned T    = 8;
   localparam int unsigned MAXA = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        card_in, key_valid, auth_done, auth_ok, session_end, admin_unlock;
   logic [3:0]  card_acc_num, key_code;
   logic        auth_req, session_ok, locked, card_eject;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic [2:0]  digit_cnt;
   logic [1:0]  fail_cnt;

   always #5 clk = ~clk;

   pin_entry_ctrl #(
      .MAX_ATTEMPTS  (MAXA),
      .TIMEOUT_CYCLES(T),
      .TMR_W         (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .card_in     (card_in),
      .card_acc_num(card_acc_num),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .auth_done   (auth_done),
      .auth_ok     (auth_ok),
      .session_end (session_end),
      .admin_unlock(admin_unlock),
      .auth_req    (auth_req),
      .acc_num     (acc_num),
      .pin         (pin),
      .digit_cnt   (digit_cnt),
      .fail_cnt    (fail_cnt),
      .session_ok  (session_ok),
      .locked      (locked),
      .card_eject  (card_eject)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: customer-level view of the session.
   localparam int M_IDLE = 0, M_ENTRY = 1, M_WAIT = 2, M_GRANTED = 3, M_LOCKED = 4;
   int m_mode;
   int m_acc;
   int m_digits[$];
   int m_fail;
   int m_quiet;
   bit m_eject;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_pin();
      int p = 0;
      foreach (m_digits[i]) p = p * 10 + m_digits[i];
      return p;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_acc = 0; m_digits.delete(); m_fail = 0; m_quiet = 0; m_eject = 0;
   endtask

   task automatic leave_to_idle(input bit ej);
      m_eject = ej; m_mode = M_IDLE; m_digits.delete();
   endtask

   task automatic model_edge();
      int k;
      m_eject = 0;
      k = int'(key_code);
      case (m_mode)
         M_IDLE: if (card_in) begin
            m_acc = int'(card_acc_num); m_digits.delete(); m_fail = 0; m_quiet = 0;
            m_mode = M_ENTRY;
         end
         M_ENTRY: begin
            if (key_valid) begin
               m_quiet = 0;
               if (k <= 9) begin
                  if (m_digits.size() < 4) m_digits.push_back(k);
               end else if (k == 10) m_digits.delete();
               else if (k == 11) begin
                  if (m_digits.size() == 4) m_mode = M_WAIT;
               end else if (k == 12) leave_to_idle(1);
            end else if (m_quiet == T - 1) leave_to_idle(1);
            else m_quiet++;
         end
         M_WAIT: if (auth_done) begin
            if (auth_ok) m_mode = M_GRANTED;
            else if (m_fail + 1 == MAXA) begin m_fail++; m_mode = M_LOCKED; end
            else begin m_fail++; m_digits.delete(); m_quiet = 0; m_mode = M_ENTRY; end
         end
         M_GRANTED: if (session_end) leave_to_idle(1);
         M_LOCKED: if (admin_unlock) begin m_fail = 0; leave_to_idle(0); end
         default: ;
      endcase
   endtask

   task automatic check_all();
      chk("auth_req",   auth_req,   m_mode == M_WAIT);
      chk("acc_num",    acc_num,    m_acc);
      chk("pin",        pin,        exp_pin());
      chk("digit_cnt",  digit_cnt,  m_digits.size());
      chk("fail_cnt",   fail_cnt,   m_fail);
      chk("session_ok", session_ok, m_mode == M_GRANTED);
      chk("locked",     locked,     m_mode == M_LOCKED);
      chk("card_eject", card_eject, m_eject);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      card_in = 0; key_valid = 0; auth_done = 0; session_end = 0; admin_unlock = 0;
   endtask

   task automatic card(input int a);
      card_in = 1; card_acc_num = 4'(a); step();
   endtask

   task automatic key(input int k);
      key_valid = 1; key_code = 4'(k); step();
   endtask

   task automatic respond(input bit ok);
      auth_done = 1; auth_ok = ok; step();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; card_in = 0; key_valid = 0; auth_done = 0; auth_ok = 0;
      session_end = 0; admin_unlock = 0; card_acc_num = '0; key_code = '0;
      model_reset();
      #13;
      check_all();
      @(negedge clk) rst_n = 1;

      // 1: basic grant and session end
      card(3);
      key(4); key(5); key(6); key(7); key(11);
      chk("t1_pin", pin, 16'd4567);
      chk("t1_req", auth_req, 1);
      idle(3);
      respond(1);
      chk("t1_ok", session_ok, 1);
      session_end = 1; step();
      chk("t1_eject", card_eject, 1);
      step();
      chk("t1_eject_pulse", card_eject, 0);

      // 2: clear, full entry, ignored fifth digit
      card(5);
      key(1); key(2); key(10); key(9); key(0); key(1); key(2);
      chk("t2_pin", pin, 16'd9012);
      chk("t2_cnt", digit_cnt, 3'd4);
      key(7);
      chk("t2_5th", pin, 16'd9012);
      key(11);

      // 3: three rejects lead to lockout
      respond(0);
      chk("t3_f1", fail_cnt, 2'd1);
      key(1); key(1); key(1); key(1); key(11);
      respond(0);
      chk("t3_f2", fail_cnt, 2'd2);
      key(2); key(2); key(2); key(2); key(11);
      respond(0);
      chk("t3_lock", locked, 1);
      chk("t3_noeject", card_eject, 0);
      card(7); key(1); idle(T + 2);
      admin_unlock = 1; step();
      chk("t3_unlock", locked, 0);
      chk("t3_fail0", fail_cnt, 2'd0);
      chk("t3_noeject2", card_eject, 0);

      // 4: short ENTER ignored, codes D/E restart the timer
      card(1);
      key(1); key(2); key(3); key(11);
      chk("t4_req", auth_req, 0);
      chk("t4_cnt", digit_cnt, 3'd3);
      idle(T - 2); key(13); idle(T - 2); key(14);
      chk("t4_alive", card_eject, 0);

      // 5: key in the expiry cycle wins, then a full quiet window ejects
      idle(T - 1); key(15);
      chk("t5_key_wins", card_eject, 0);
      idle(T - 1);
      chk("t5_pre", card_eject, 0);
      step();
      chk("t5_eject", card_eject, 1);

      // 6: asynchronous reset while waiting for the authenticator
      card(2);
      key(1); key(2); key(3); key(4); key(11); respond(0);
      key(5); key(6); key(7); key(8); key(11);
      #2 rst_n = 0;
      #1 model_reset();
      chk("t6_req", auth_req, 0);
      chk("t6_pin", pin, 16'd0);
      chk("t6_fail", fail_cnt, 2'd0);
      check_all();
      @(negedge clk) rst_n = 1;
      card(9);
      chk("t6_acc", acc_num, 4'd9);
      key(3);
      chk("t6_pin2", pin, 16'd3);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         card_in      = ($urandom_range(0, 7) == 0);
         card_acc_num = 4'($urandom);
         key_valid    = ($urandom_range(0, 1) == 0);
         key_code     = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 9))
                                                  : 4'($urandom_range(10, 15));
         auth_done    = ($urandom_range(0, 3) == 0);
         auth_ok      = ($urandom_range(0, 1) == 0);
         session_end  = ($urandom_range(0, 7) == 0);
         admin_unlock = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
